// File: rtl/cp0_exc.sv
// Coprocessor-0 exception responder: answers writeback exception records and holds Status/Cause/EPC/BadVAddr/Count/Compare.
// Optional: define CP0_TIMER_INT_EN to add the Count/Compare timer interrupt (Cause.TI, IP[7]).
module cp0_exc #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                S_WBU_CP0_exception_tvalid,
    output logic                S_WBU_CP0_exception_tready,
    input  logic [31:0]         S_WBU_CP0_exception_etw,
    input  logic [31:0]         S_WBU_CP0_exception_cur_inst_addr,
    input  logic [31:0]         S_WBU_CP0_exception_badvaddr,
    input  logic                S_WBU_CP0_exception_isdelayslot,
    input  logic                S_WBU_CP0_exception_valid,
    input  logic                S_WBU_CP0_exception_exception_handle,
    input  logic                S_WBU_CP0_exception_int_enable,
    output logic                M_CP0_WBU_exception_tvalid,
    output logic                M_CP0_WBU_exception_has_exception,
    output logic                M_CP0_WBU_exception_eret,
    output logic [31:0]         M_CP0_WBU_exception_epc,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic [7:0]          cp0_raddr,
    output logic [31:0]         cp0_rdata,
    input  logic                cp0_wen,
    input  logic [7:0]          cp0_waddr,
    input  logic [31:0]         cp0_wdata
);

    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    exc_code_e   exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;

    logic        acc;
    logic [7:0]  ip_full;
    logic        int_pend;
    logic        take_int;
    logic        etw_exc;
    logic        has_exc;
    logic        eret_out;
    exc_code_e   exc_code;
    logic        bad_upd;
    logic [31:0] bad_val;
    logic [5:0]  hw_ext;
    logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;
    logic        unused_etw;

    assign unused_etw = ^S_WBU_CP0_exception_etw[31:8];
    assign hw_ext     = 6'(hw_int);

    // Reset forces the response low even if a record is presented during reset.
    assign acc      = S_WBU_CP0_exception_tvalid & S_WBU_CP0_exception_valid
                    & S_WBU_CP0_exception_exception_handle & ~rst;
    assign ip_full  = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
    assign int_pend = ie_q & ~exl_q & (|(ip_full & im_q));
    assign take_int = acc & S_WBU_CP0_exception_int_enable & int_pend;
    assign etw_exc  = |S_WBU_CP0_exception_etw[7:1];
    assign has_exc  = acc & (take_int | etw_exc);
    assign eret_out = acc & S_WBU_CP0_exception_etw[0] & ~has_exc;

    always_comb begin
        exc_code = EXC_INT;
        bad_upd  = 1'b0;
        bad_val  = S_WBU_CP0_exception_cur_inst_addr;
        if (take_int) begin
            exc_code = EXC_INT;
        end else if (S_WBU_CP0_exception_etw[5]) begin
            exc_code = EXC_ADEL;
            bad_upd  = 1'b1;
        end else if (S_WBU_CP0_exception_etw[3]) begin
            exc_code = EXC_RI;
        end else if (S_WBU_CP0_exception_etw[4]) begin
            exc_code = EXC_OV;
        end else if (S_WBU_CP0_exception_etw[1]) begin
            exc_code = EXC_SYS;
        end else if (S_WBU_CP0_exception_etw[2]) begin
            exc_code = EXC_BP;
        end else if (S_WBU_CP0_exception_etw[6]) begin
            exc_code = EXC_ADEL;
            bad_upd  = 1'b1;
            bad_val  = S_WBU_CP0_exception_badvaddr;
        end else if (S_WBU_CP0_exception_etw[7]) begin
            exc_code = EXC_ADES;
            bad_upd  = 1'b1;
            bad_val  = S_WBU_CP0_exception_badvaddr;
        end
    end

    assign wr_status  = cp0_wen & (cp0_waddr == ADDR_STATUS);
    assign wr_cause   = cp0_wen & (cp0_waddr == ADDR_CAUSE);
    assign wr_epc     = cp0_wen & (cp0_waddr == ADDR_EPC);
    assign wr_count   = cp0_wen & (cp0_waddr == ADDR_COUNT);
    assign wr_compare = cp0_wen & (cp0_waddr == ADDR_COMPARE);

    // mtc0 is applied first so that exception/eret updates override colliding fields.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_hw_d    = hw_ext;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        toggle_d   = toggle_q;

        if (wr_status) begin
            im_d  = cp0_wdata[15:8];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
        end
        if (wr_cause) begin
            ip_sw_d = cp0_wdata[1:0];
        end
        if (wr_epc) begin
            epc_d = cp0_wdata;
        end
        if (wr_compare) begin
            compare_d = cp0_wdata;
        end
        if (wr_count) begin
            count_d  = cp0_wdata;
            toggle_d = 1'b0;
        end else begin
            toggle_d = ~toggle_q;
            if (toggle_q) begin
                count_d = count_q + 32'd1;
            end
        end

`ifdef CP0_TIMER_INT_EN
        // TI fires on the increment that lands on Compare; a Compare write re-arms it.
        if (!wr_count && toggle_q && ((count_q + 32'd1) == compare_q)) begin
            ti_d = 1'b1;
        end
        if (wr_compare) begin
            ti_d = 1'b0;
        end
`else
        ti_d = 1'b0;
`endif

        if (has_exc) begin
            if (!exl_q) begin
                epc_d = S_WBU_CP0_exception_isdelayslot
                      ? S_WBU_CP0_exception_cur_inst_addr - 32'd4
                      : S_WBU_CP0_exception_cur_inst_addr;
                bd_d  = S_WBU_CP0_exception_isdelayslot;
            end
            exl_d      = 1'b1;
            exc_code_d = exc_code;
            if (bad_upd) begin
                badvaddr_d = bad_val;
            end
        end else if (eret_out) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q       <= 8'h00;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= 6'h00;
            ip_sw_q    <= 2'b00;
            exc_code_q <= EXC_INT;
            epc_q      <= 32'h0;
            badvaddr_q <= 32'h0;
            count_q    <= 32'h0;
            compare_q  <= 32'h0;
            toggle_q   <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            toggle_q   <= toggle_d;
        end
    end

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_raddr)
            ADDR_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
            ADDR_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'b0, ip_full, 1'b0, exc_code_q, 2'b0};
            ADDR_EPC:      cp0_rdata = epc_q;
            ADDR_BADVADDR: cp0_rdata = badvaddr_q;
            ADDR_COUNT:    cp0_rdata = count_q;
            ADDR_COMPARE:  cp0_rdata = compare_q;
            default:       cp0_rdata = 32'h0;
        endcase
    end

    assign S_WBU_CP0_exception_tready        = 1'b1;
    assign M_CP0_WBU_exception_tvalid        = 1'b1;
    assign M_CP0_WBU_exception_has_exception = has_exc;
    assign M_CP0_WBU_exception_eret          = eret_out;
    assign M_CP0_WBU_exception_epc           = has_exc  ? EXC_VECTOR :
                                               eret_out ? epc_q      : 32'h0;

endmodule
